// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit accumulator CPU.
// Imported by both the datapath and the control unit.
package cpu_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;

    localparam logic [2:0] BUS_NONE = 3'b000;
    localparam logic [2:0] BUS_AR   = 3'b001;
    localparam logic [2:0] BUS_PC   = 3'b010;
    localparam logic [2:0] BUS_DR   = 3'b011;
    localparam logic [2:0] BUS_AC   = 3'b100;
    localparam logic [2:0] BUS_IR   = 3'b101;
    localparam logic [2:0] BUS_TR   = 3'b110;
    localparam logic [2:0] BUS_MEM  = 3'b111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_PASS = 3'b101;
    localparam logic [2:0] ALU_LDA  = 3'b110;
    localparam logic [2:0] ALU_NOT  = 3'b111;

endpackage

// File: rtl/cpu_datapath_reg.sv
// Datapath register with clear > load > inc priority.
// Increment wraps modulo 2^W.
module dp_reg #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (inc) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/cpu_datapath.sv
// Register-transfer datapath of the 8-bit accumulator CPU:
// registers, common bus, ALU and memory port.
module cpu_datapath
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_AR,
    input  logic              load_PC,
    input  logic              load_DR,
    input  logic              load_AC,
    input  logic              load_IR,
    input  logic              load_TR,
    input  logic              clear_AR,
    input  logic              clear_PC,
    input  logic              clear_DR,
    input  logic              clear_AC,
    input  logic              clear_TR,
    input  logic              inc_AR,
    input  logic              inc_PC,
    input  logic              inc_DR,
    input  logic              inc_AC,
    input  logic              inc_TR,
    input  logic              memory_read,
    input  logic              memory_write,
    input  logic [2:0]        bus_selectors,
    input  logic              alu_enable,
    input  logic [2:0]        alu_mode,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] IR,
    output logic              carry,
    output logic              zero
);

    logic [ADDR_W-1:0] ar;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] dr;
    logic [DATA_W-1:0] ac;
    logic [DATA_W-1:0] tr;
    logic [DATA_W-1:0] bus;
    logic [DATA_W-1:0] ac_d;
    logic [DATA_W:0]   alu_out;
    logic              carry_upd;

    // Result in [DATA_W-1:0], carry/no-borrow in [DATA_W].
    function automatic logic [DATA_W:0] alu(
        input logic [2:0]        mode,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W:0] r;
        r = '0;
        case (mode)
            ALU_ADD:  r = {1'b0, a} + {1'b0, b};
            ALU_SUB:  r = {1'b0, a} + {1'b0, ~b} + (DATA_W + 1)'(1);
            ALU_AND:  r = {1'b0, a & b};
            ALU_OR:   r = {1'b0, a | b};
            ALU_XOR:  r = {1'b0, a ^ b};
            ALU_PASS: r = {1'b0, a};
            ALU_LDA:  r = {1'b0, b};
            default:  r = {1'b0, ~a};
        endcase
        return r;
    endfunction

    always_comb begin
        bus = '0;
        unique case (bus_selectors)
            BUS_NONE: bus = '0;
            BUS_AR:   bus = DATA_W'(ar);
            BUS_PC:   bus = DATA_W'(pc);
            BUS_DR:   bus = dr;
            BUS_AC:   bus = ac;
            BUS_IR:   bus = IR;
            BUS_TR:   bus = tr;
            BUS_MEM:  bus = mem_rdata;
        endcase
    end

    assign alu_out   = alu(alu_mode, ac, dr);
    assign ac_d      = alu_enable ? alu_out[DATA_W-1:0] : bus;
    assign carry_upd = alu_enable & load_AC &
                       ((alu_mode == ALU_ADD) | (alu_mode == ALU_SUB));

    dp_reg #(.W(ADDR_W)) u_ar (
        .clock(clock), .reset(reset), .clear(clear_AR),
        .load(load_AR), .inc(inc_AR), .d(bus[ADDR_W-1:0]), .q(ar)
    );

    dp_reg #(.W(ADDR_W)) u_pc (
        .clock(clock), .reset(reset), .clear(clear_PC),
        .load(load_PC), .inc(inc_PC), .d(bus[ADDR_W-1:0]), .q(pc)
    );

    dp_reg #(.W(DATA_W)) u_dr (
        .clock(clock), .reset(reset), .clear(clear_DR),
        .load(load_DR), .inc(inc_DR), .d(bus), .q(dr)
    );

    dp_reg #(.W(DATA_W)) u_ac (
        .clock(clock), .reset(reset), .clear(clear_AC),
        .load(load_AC), .inc(inc_AC), .d(ac_d), .q(ac)
    );

    dp_reg #(.W(DATA_W)) u_tr (
        .clock(clock), .reset(reset), .clear(clear_TR),
        .load(load_TR), .inc(inc_TR), .d(bus), .q(tr)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            IR    <= '0;
            carry <= 1'b0;
        end else begin
            if (load_IR) begin
                IR <= bus;
            end
            if (carry_upd) begin
                carry <= alu_out[DATA_W];
            end
        end
    end

    assign mem_addr  = ar;
    assign mem_wdata = bus;
    assign mem_we    = memory_write;
    assign mem_re    = memory_read;
    assign zero      = (ac == '0);

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed self-checking bench for cpu_datapath.
// Registers are observed through the bus via mem_wdata.
module tb_cpu_datapath;

    logic       clock = 1'b0;
    logic       reset;
    logic       load_AR, load_PC, load_DR, load_AC, load_IR, load_TR;
    logic       clear_AR, clear_PC, clear_DR, clear_AC, clear_TR;
    logic       inc_AR, inc_PC, inc_DR, inc_AC, inc_TR;
    logic       memory_read, memory_write;
    logic [2:0] bus_selectors;
    logic       alu_enable;
    logic [2:0] alu_mode;
    logic [7:0] mem_rdata;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we, mem_re;
    logic [7:0] IR;
    logic       carry, zero;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    cpu_datapath dut (
        .clock(clock), .reset(reset),
        .load_AR(load_AR), .load_PC(load_PC), .load_DR(load_DR),
        .load_AC(load_AC), .load_IR(load_IR), .load_TR(load_TR),
        .clear_AR(clear_AR), .clear_PC(clear_PC), .clear_DR(clear_DR),
        .clear_AC(clear_AC), .clear_TR(clear_TR),
        .inc_AR(inc_AR), .inc_PC(inc_PC), .inc_DR(inc_DR),
        .inc_AC(inc_AC), .inc_TR(inc_TR),
        .memory_read(memory_read), .memory_write(memory_write),
        .bus_selectors(bus_selectors), .alu_enable(alu_enable),
        .alu_mode(alu_mode), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re),
        .IR(IR), .carry(carry), .zero(zero)
    );

    task automatic idle();
        reset = 0;
        {load_AR, load_PC, load_DR, load_AC, load_IR, load_TR} = '0;
        {clear_AR, clear_PC, clear_DR, clear_AC, clear_TR} = '0;
        {inc_AR, inc_PC, inc_DR, inc_AC, inc_TR} = '0;
        memory_read = 0;
        memory_write = 0;
        bus_selectors = 3'b000;
        alu_enable = 0;
        alu_mode = 3'b000;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        idle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Peek a register by routing it onto the bus (no edge taken).
    task automatic peek(input string tag, input logic [2:0] sel,
                        input logic [7:0] exp);
        bus_selectors = sel;
        #1;
        chk(tag, mem_wdata, exp);
        bus_selectors = 3'b000;
        #1;
    endtask

    // 0 AR, 1 PC, 2 DR, 3 AC, 4 TR
    task automatic ldmem(input int r, input logic [7:0] v);
        mem_rdata = v;
        bus_selectors = 3'b111;
        case (r)
            0: load_AR = 1;
            1: load_PC = 1;
            2: load_DR = 1;
            3: load_AC = 1;
            default: load_TR = 1;
        endcase
        tick();
    endtask

    task automatic alu_op(input logic [2:0] m);
        alu_enable = 1;
        alu_mode = m;
        load_AC = 1;
        tick();
    endtask

    initial begin
        idle();
        mem_rdata = 8'hA5;
        reset = 1;
        @(posedge clock);
        #1;
        idle();
        #1;
        chk("rst_ar", mem_addr, 8'h00);
        peek("rst_pc", 3'b010, 8'h00);
        peek("rst_dr", 3'b011, 8'h00);
        peek("rst_ac", 3'b100, 8'h00);
        chk("rst_ir", IR, 8'h00);
        peek("rst_tr", 3'b110, 8'h00);
        chk("rst_carry", {7'b0, carry}, 8'h00);
        chk("rst_zero", {7'b0, zero}, 8'h01);
        peek("bus_none", 3'b000, 8'h00);
        peek("bus_mem", 3'b111, 8'hA5);

        repeat (3) tick();
        peek("idle_pc", 3'b010, 8'h00);
        chk("idle_ir", IR, 8'h00);

        // Fetch
        ldmem(1, 8'h10);
        mem_rdata = 8'h93;
        bus_selectors = 3'b010;
        load_AR = 1;
        tick();
        chk("fetch_ar", mem_addr, 8'h10);
        peek("bus_ar", 3'b001, 8'h10);
        bus_selectors = 3'b111;
        load_IR = 1;
        inc_PC = 1;
        tick();
        chk("fetch_ir", IR, 8'h93);
        peek("fetch_pc", 3'b010, 8'h11);
        peek("bus_ir", 3'b101, 8'h93);

        // ALU
        ldmem(3, 8'hF0);
        ldmem(2, 8'h20);
        alu_op(3'b000);
        peek("add_ac", 3'b100, 8'h10);
        chk("add_carry", {7'b0, carry}, 8'h01);
        chk("add_zero", {7'b0, zero}, 8'h00);
        ldmem(3, 8'h20);
        chk("hold_carry", {7'b0, carry}, 8'h01);
        alu_op(3'b001);
        peek("sub_ac", 3'b100, 8'h00);
        chk("sub_carry", {7'b0, carry}, 8'h01);
        chk("sub_zero", {7'b0, zero}, 8'h01);
        ldmem(3, 8'h10);
        alu_op(3'b001);
        peek("sub_borrow_ac", 3'b100, 8'hF0);
        chk("sub_borrow_c", {7'b0, carry}, 8'h00);
        alu_op(3'b010);
        peek("and_ac", 3'b100, 8'h20);
        alu_op(3'b011);
        peek("or_ac", 3'b100, 8'h20);
        alu_op(3'b111);
        peek("not_ac", 3'b100, 8'hDF);
        alu_op(3'b100);
        peek("xor_ac", 3'b100, 8'hFF);
        alu_op(3'b110);
        peek("lda_ac", 3'b100, 8'h20);
        chk("logic_carry", {7'b0, carry}, 8'h00);

        // Priority and wrap
        ldmem(3, 8'h55);
        bus_selectors = 3'b100;
        clear_TR = 1;
        load_TR = 1;
        inc_TR = 1;
        tick();
        peek("prio_tr", 3'b110, 8'h00);
        ldmem(4, 8'hFF);
        inc_TR = 1;
        tick();
        peek("wrap_tr", 3'b110, 8'h00);
        load_TR = 1;
        inc_TR = 1;
        bus_selectors = 3'b100;
        tick();
        peek("load_over_inc", 3'b110, 8'h55);

        // Store
        ldmem(3, 8'h7A);
        ldmem(0, 8'h33);
        bus_selectors = 3'b100;
        memory_write = 1;
        alu_enable = 1;
        alu_mode = 3'b101;
        load_AC = 1;
        #1;
        chk("st_addr", mem_addr, 8'h33);
        chk("st_wdata", mem_wdata, 8'h7A);
        chk("st_we", {7'b0, mem_we}, 8'h01);
        chk("st_re", {7'b0, mem_re}, 8'h00);
        tick();
        peek("st_ac", 3'b100, 8'h7A);
        memory_read = 1;
        #1;
        chk("rd_re", {7'b0, mem_re}, 8'h01);
        chk("rd_we", {7'b0, mem_we}, 8'h00);

        // Same-edge source and increment
        bus_selectors = 3'b010;
        load_AR = 1;
        inc_PC = 1;
        tick();
        chk("same_ar", mem_addr, 8'h11);
        peek("same_pc", 3'b010, 8'h12);

        // Reset mid-transfer
        ldmem(2, 8'h44);
        bus_selectors = 3'b011;
        load_AC = 1;
        inc_PC = 1;
        load_IR = 1;
        reset = 1;
        tick();
        peek("mid_ac", 3'b100, 8'h00);
        peek("mid_pc", 3'b010, 8'h00);
        peek("mid_dr", 3'b011, 8'h00);
        chk("mid_ir", IR, 8'h00);
        chk("mid_ar", mem_addr, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_datapath.md
# cpu_datapath

- Register-transfer datapath of the 8-bit accumulator CPU.
- Consumes every control strobe issued by the control unit and implements the registers, common bus, ALU and memory port they drive.
- Returns the instruction register to the control unit, along with result flags.
- Sits between the control unit and the external memory.

## Interface

Parameters:
- DATA_W, 8, width of bus, DR, AC, IR, TR
- ADDR_W, 8, width of AR, PC and memory address (ADDR_W <= DATA_W)

Ports:
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all registers
- load_AR/PC/DR/AC/IR/TR  in  1 each  load register on next edge
- clear_AR/PC/DR/AC/TR  in  1 each  clear register to 0 on next edge
- inc_AR/PC/DR/AC/TR  in  1 each  increment register on next edge
- memory_read  in  1  read enable forwarded to memory
- memory_write  in  1  write enable forwarded to memory
- bus_selectors  in  3  common-bus source select
- alu_enable  in  1  AC load takes ALU result instead of bus
- alu_mode  in  3  ALU operation
- mem_rdata  in  DATA_W  combinational read data from memory at mem_addr
- mem_addr  out  ADDR_W  equals AR
- mem_wdata  out  DATA_W  equals current bus value
- mem_we  out  1  equals memory_write
- mem_re  out  1  equals memory_read
- IR  out  DATA_W  instruction register, to control unit
- carry  out  1  E flag, updated by ALU ADD/SUB
- zero  out  1  combinational, AC == 0

## Operation

Bus sources, selected by bus_selectors:
- 000 zero
- 001 AR, zero-extended
- 010 PC, zero-extended
- 011 DR
- 100 AC
- 101 IR
- 110 TR
- 111 mem_rdata, independent of memory_read

Register loads:
- Every register loads from the bus.
- AR and PC take bus[ADDR_W-1:0].
- AC is the exception: when alu_enable=1, AC loads the ALU result instead of the bus.
- Per-register priority: clear > load > inc.
- IR has load only.

Increment:
- Modulo 2^width; 0xFF wraps to 0x00.
- No flag is affected.

ALU operations, all modulo 2^DATA_W:
- 000 ADD: AC+DR; carry = carry-out.
- 001 SUB: AC-DR; carry = 1 if no borrow.
- 010 AND
- 011 OR
- 100 XOR
- 101 PASS AC. This is the store opcode; AC is unchanged.
- 110 LDA: result = DR.
- 111 NOT AC.

Carry flag:
- Updated only on edges where alu_enable & load_AC & mode is ADD or SUB.
- Otherwise it holds.

Memory port:
- mem_wdata and mem_we are pure pass-through.
- Memory samples them on the same edge on which the datapath registers update.

## Timing

- All registers and carry reset to 0 on the first edge with reset=1; this includes IR and PC. IR reads 0x00 after reset.
- Outputs follow with zero added latency:
  - mem_addr, IR and carry are register outputs.
  - zero, mem_wdata, mem_we and mem_re are combinational from registers and inputs.
- A register transfer completes in one cycle: value on the bus at edge N appears in the destination after edge N.
- Same-edge read/write: a register that is both bus source and destination, or incremented while sourcing, drives its old value. Example: PC->AR together with inc_PC gives AR = old PC and PC = old+1.
- Multiple loads from one bus in the same cycle are legal; all receive the same value.
- Reset overrides all strobes in the same cycle, including mid-instruction. No partial update occurs.
- Undefined bus_selectors encodings do not exist; all 8 are decoded.

## Structure

- Package cpu_pkg holds:
  - bus-select constants: BUS_NONE, BUS_AR, BUS_PC, BUS_DR, BUS_AC, BUS_IR, BUS_TR, BUS_MEM
  - ALU mode constants: ALU_ADD … ALU_NOT
  - width defaults
- The control unit imports the same package.
- One natural sub-module: dp_reg, a parameterized register with clear/load/inc and the fixed priority. It is instantiated for AR, PC, DR, AC and TR.
- The ALU is a combinational function inside cpu_datapath.

## Test plan

- Reset → AR=PC=DR=AC=IR=TR=0, carry=0, zero=1. Hold all strobes 0 for 3 cycles → no change.
- Fetch:
  - Set PC=0x10 and mem_rdata=0x93.
  - Cycle 1: bus=010 with load_AR → AR=0x10.
  - Cycle 2: bus=111 with load_IR and inc_PC → IR=0x93, PC=0x11.
- ALU: AC=0xF0, DR=0x20.
  - ADD → AC=0x10, carry=1, zero=0.
  - SUB on AC=0x20, DR=0x20 → AC=0x00, carry=1, zero=1.
- Priority and wrap:
  - Assert clear_TR, load_TR and inc_TR together with bus=AC(0x55) → TR=0.
  - Then inc_TR with TR=0xFF → TR=0x00.
- Store: AC=0x7A, AR=0x33, bus=100, memory_write=1 → mem_addr=0x33, mem_wdata=0x7A, mem_we=1, AC unchanged.
- Reset mid-transfer: assert reset together with load_AC (bus=DR=0x44) and inc_PC → AC=0, PC=0 after the edge.
